amp_gain_ctrl: RTL

AMP_GAIN_CTRL -- requirements
Module: amp_gain_ctrl

---
 rtl/amp_pkg.sv | 19 +
 rtl/amp_sck_gen.sv | 64 ++++++
 rtl/amp_gain_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/amp_pkg.sv
// Shared definitions for the amplifier gain controller: FSM state encoding
// and the frame-width derivation used by the top level for its port widths.
package amp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } amp_state_e;

  // Total serial frame width: one GAIN_W field per channel, channel 0 in the LSBs.
  function automatic int unsigned frame_w(input int unsigned channels,
                                          input int unsigned gain_w);
    return channels * gain_w;
  endfunction

endpackage

// File: rtl/amp_sck_gen.sv
// SCK timing generator: divides the system clock by CLK_DIV and emits
// alternating registered rise/fall strobes, the first one being a rise.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   en_i        count enable (SETUP/SHIFT/HOLD)
//   clr_i       synchronous clear of counter and phase (IDLE)
//   rise_tick_o one-cycle strobe: SCK should go high on the next edge
//   fall_tick_o one-cycle strobe: SCK should go low on the next edge
module amp_sck_gen #(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Strobe is issued one cycle early so it lands registered on every CLK_DIV-th cycle.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(CLK_DIV - 2)) begin
        rise_d  = ~phase_q;
        fall_d  = phase_q;
        phase_d = ~phase_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise_tick_o = rise_q;
  assign fall_tick_o = fall_q;

endmodule

// File: rtl/amp_gain_ctrl.sv
// Programmable-gain amplifier controller: shifts a gain frame out over SPI
// (MSB first), captures the readback on amp_dout, and flags when the readback
// differs from the frame sent in the previous transfer.
// Ports:
//   CLK50MHZ, RST_N   clock, asynchronous active-low reset
//   amp_trig          start request (ignored unless idle)
//   amp_gain          gain word, channel 0 in the LSBs
//   amp_shdn_req      shutdown request, sampled only while idle
//   amp_dout          serial readback from the amplifier
//   spi_sck/spi_mosi  serial clock (idles low) and data
//   amp_cs            chip select, active low
//   amp_shdn          registered shutdown output
//   amp_busy          transfer in progress
//   amp_done          one-cycle completion pulse (decoded from state)
//   amp_rdata         captured readback word
//   amp_verr          readback mismatch against previous frame
module amp_gain_ctrl
  import amp_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned GAIN_W   = 4,
  parameter int unsigned CLK_DIV  = 6
) (
  input  logic                                  CLK50MHZ,
  input  logic                                  RST_N,
  input  logic                                  amp_trig,
  input  logic [frame_w(CHANNELS, GAIN_W)-1:0]  amp_gain,
  input  logic                                  amp_shdn_req,
  input  logic                                  amp_dout,
  output logic                                  spi_sck,
  output logic                                  spi_mosi,
  output logic                                  amp_cs,
  output logic                                  amp_shdn,
  output logic                                  amp_busy,
  output logic                                  amp_done,
  output logic [frame_w(CHANNELS, GAIN_W)-1:0]  amp_rdata,
  output logic                                  amp_verr
);

  localparam int unsigned FRAME_W = frame_w(CHANNELS, GAIN_W);
  localparam int unsigned BCNT_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  amp_state_e         state_q, state_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] prev_word_q, prev_word_d;
  logic [FRAME_W-1:0] rdata_q, rdata_d;
  logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic               prev_valid_q, prev_valid_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               shdn_q, shdn_d;
  logic               busy_q, busy_d;
  logic               verr_q, verr_d;

  logic               sck_en, sck_clr;
  logic               rise_tick, fall_tick;

  // Divider runs only while the frame is active and restarts from zero each frame.
  assign sck_en  = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign sck_clr = (state_q == IDLE);

  amp_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i       (CLK50MHZ),
    .rst_ni      (RST_N),
    .en_i        (sck_en),
    .clr_i       (sck_clr),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    frame_d      = frame_q;
    prev_word_d  = prev_word_q;
    prev_valid_d = prev_valid_q;
    rdata_d      = rdata_q;
    bit_cnt_d    = bit_cnt_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    cs_d         = cs_q;
    shdn_d       = shdn_q;
    busy_d       = busy_q;
    verr_d       = verr_q;

    unique case (state_q)
      IDLE: begin
        shdn_d = amp_shdn_req;
        if (amp_trig) begin
          state_d   = SETUP;
          frame_d   = amp_gain;
          tx_d      = amp_gain;
          mosi_d    = amp_gain[FRAME_W-1];
          rx_d      = '0;
          bit_cnt_d = '0;
          cs_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      SETUP, SHIFT: begin
        if (rise_tick) begin
          state_d = SHIFT;
          sck_d   = 1'b1;
          rx_d    = (rx_q << 1) | FRAME_W'(amp_dout);
        end else if (fall_tick) begin
          sck_d = 1'b0;
          if (bit_cnt_q == BCNT_W'(FRAME_W - 1)) begin
            state_d = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            tx_d      = tx_q << 1;
            mosi_d    = tx_d[FRAME_W-1];
          end
        end
      end

      // The strobe after the last fall closes the frame.
      HOLD: begin
        if (rise_tick) begin
          state_d      = DONE;
          cs_d         = 1'b1;
          busy_d       = 1'b0;
          rdata_d      = rx_q;
          verr_d       = prev_valid_q && (rx_q != prev_word_q);
          prev_word_d  = frame_q;
          prev_valid_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      frame_q      <= '0;
      prev_word_q  <= '0;
      prev_valid_q <= 1'b0;
      rdata_q      <= '0;
      bit_cnt_q    <= '0;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      cs_q         <= 1'b1;
      shdn_q       <= 1'b1;
      busy_q       <= 1'b0;
      verr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      frame_q      <= frame_d;
      prev_word_q  <= prev_word_d;
      prev_valid_q <= prev_valid_d;
      rdata_q      <= rdata_d;
      bit_cnt_q    <= bit_cnt_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      cs_q         <= cs_d;
      shdn_q       <= shdn_d;
      busy_q       <= busy_d;
      verr_q       <= verr_d;
    end
  end

  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;
  assign amp_cs    = cs_q;
  assign amp_shdn  = shdn_q;
  assign amp_busy  = busy_q;
  assign amp_done  = (state_q == DONE);
  assign amp_rdata = rdata_q;
  assign amp_verr  = verr_q;

endmodule
